// File: rtl/mem_stage.sv
// mem_stage: memory stage between execute and writeback.
// Takes the ALU result as both the address and the non-memory result.
// Loads and stores go out over a variable-latency request/done port.
// The result is registered for writeback as a one-cycle wb_valid pulse.
// Optional feature: define MEM_TIMEOUT_EN to bound the wait for mem_done
// to TIMEOUT cycles; when the wait runs out the stage moves to ERROR.
//
// Handshake (execute -> mem): an instruction transfers on a rising edge
// where ex_valid && ex_ready. ex_ready is high only in IDLE. While
// ex_ready is low, ex_valid is ignored and upstream holds its inputs.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ALU_out,
  input  logic [15:0] read2Data,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        halt,
  output logic        ex_ready,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        wb_halt,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HALTED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_rd;
  logic        cap_wr;
  logic        cap_halt;

  logic accept;
  logic is_mem;
  logic bad_req;
  logic to_hit;

  assign accept  = ex_valid && (state == S_IDLE);
  assign is_mem  = memRead || memWrite;
  // A request with both flags set, or with an odd word address, is never issued.
  assign bad_req = (memRead && memWrite) || ALU_out[0];

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;

  // to_hit is true on the edge where the wait reaches TIMEOUT cycles.
  assign to_hit = (to_cnt == CNT_W'(TIMEOUT - 1));

  // Wait counter: cleared on entry to ACCESS, counts ACCESS cycles without mem_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != S_ACCESS && state_nx == S_ACCESS) begin
      to_cnt <= '0;
    end else if (state == S_ACCESS && !mem_done) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // Without the timeout, ACCESS waits for mem_done indefinitely.
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A mem_done that arrives on the timeout edge wins.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (ex_valid) begin
          if (is_mem) begin
            state_nx = bad_req ? S_ERROR : S_ACCESS;
          end else if (halt) begin
            state_nx = S_HALTED;
          end
        end
      end
      S_ACCESS: begin
        if (mem_done) begin
          state_nx = S_IDLE;
        end else if (to_hit) begin
          state_nx = S_ERROR;
        end
      end
      default: state_nx = state;
    endcase
  end

  // Capture the instruction on an accepted handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_halt  <= 1'b0;
    end else if (accept) begin
      cap_addr  <= ALU_out;
      cap_wdata <= read2Data;
      cap_rd    <= memRead;
      cap_wr    <= memWrite;
      cap_halt  <= halt;
    end
  end

  // Writeback register: pulse wb_valid for one cycle; data and halt otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_halt  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid <= 1'b1;
        wb_data  <= ALU_out;
        wb_halt  <= halt;
      end else if (state == S_ACCESS && mem_done) begin
        wb_valid <= 1'b1;
        wb_data  <= cap_rd ? mem_rdata : cap_addr;
        wb_halt  <= cap_halt;
      end
    end
  end

  assign ex_ready  = (state == S_IDLE);
  assign mem_req   = (state == S_ACCESS);
  assign mem_wr    = mem_req && cap_wr;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign err       = (state == S_ERROR);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized bench for mem_stage.
// A word-addressed RAM model answers requests and predicts load data;
// expected writeback values are kept in exp_q.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ALU_out = '0;
  logic [15:0] read2Data = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic        ex_ready;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        wb_halt;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];
  logic [15:0] ram[logic [15:0]];

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ALU_out(ALU_out),
    .read2Data(read2Data), .memRead(memRead), .memWrite(memWrite), .halt(halt),
    .ex_ready(ex_ready), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_halt(wb_halt), .err(err)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ex_valid = 1'b0;
    mem_done = 1'b0;
    tick();
    chk1("rst_ex_ready", ex_ready, 1'b1);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 16'h0000);
    chk1("rst_wb_halt", wb_halt, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b1;
    exp_q.delete();
  endtask

  // One instruction through the stage; the memory answers after d+1 ACCESS cycles.
  task automatic issue(input logic [15:0] alu, input logic [15:0] wd,
                       input logic rd, input logic wr, input logic hl, input int d);
    logic is_mem;
    logic bad;
    is_mem = rd | wr;
    bad = (rd & wr) | (is_mem & alu[0]);
    chk1("ready_before", ex_ready, 1'b1);
    ex_valid = 1'b1; ALU_out = alu; read2Data = wd;
    memRead = rd; memWrite = wr; halt = hl;
    if (!is_mem) exp_q.push_back(alu);
    tick();
    ex_valid = 1'b0; ALU_out = 16'($urandom); read2Data = 16'($urandom);
    memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
    if (!is_mem) begin
      chk1("alu_wb_valid", wb_valid, 1'b1);
      chk("alu_wb_data", wb_data, exp_q.pop_front());
      chk1("alu_wb_halt", wb_halt, hl);
      chk1("alu_mem_req", mem_req, 1'b0);
      chk1("alu_ex_ready", ex_ready, !hl);
    end else if (bad) begin
      chk1("bad_mem_req", mem_req, 1'b0);
      chk1("bad_err", err, 1'b1);
      chk1("bad_ex_ready", ex_ready, 1'b0);
      chk1("bad_wb_valid", wb_valid, 1'b0);
    end else begin
      if (rd) begin
        if (!ram.exists(alu)) ram[alu] = 16'($urandom);
        exp_q.push_back(ram[alu]);
      end else begin
        ram[alu] = wd;
        exp_q.push_back(alu);
      end
      for (int i = 0; i <= d; i++) begin
        chk1("acc_mem_req", mem_req, 1'b1);
        chk1("acc_mem_wr", mem_wr, wr);
        chk("acc_mem_addr", mem_addr, alu);
        if (wr) chk("acc_mem_wdata", mem_wdata, wd);
        chk1("acc_ex_ready", ex_ready, 1'b0);
        chk1("acc_wb_valid", wb_valid, 1'b0);
        mem_done = (i == d);
        mem_rdata = (i == d && rd) ? ram[alu] : 16'($urandom);
        tick();
      end
      mem_done = 1'b0;
      chk1("mem_wb_valid", wb_valid, 1'b1);
      chk("mem_wb_data", wb_data, exp_q.pop_front());
      chk1("mem_wb_halt", wb_halt, 1'b0);
      chk1("mem_req_drop", mem_req, 1'b0);
      chk1("mem_ex_ready", ex_ready, 1'b1);
    end
  endtask

  // Directed steps followed by randomized traffic.
  initial begin
    logic [15:0] a;
    logic [15:0] w;
    int k;
    do_reset();

    // ADD result with latency 1, then the pulse ends and data holds.
    issue(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    tick();
    chk1("add_pulse_end", wb_valid, 1'b0);
    chk("add_hold", wb_data, 16'h1234);

    // Load 0x0040 answered after 3 ACCESS cycles.
    ram[16'h0040] = 16'hBEEF;
    issue(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    tick();
    chk1("load_pulse_end", wb_valid, 1'b0);

    // Store 0x5A5A to 0x0100 answered in the first ACCESS cycle, then read it back.
    issue(16'h0100, 16'h5A5A, 1'b0, 1'b1, 1'b0, 0);
    issue(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1);

    // mem_done outside ACCESS is ignored.
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0;
    chk1("idle_done_wb", wb_valid, 1'b0);
    chk1("idle_done_ready", ex_ready, 1'b1);

    // Misaligned load: ERROR is sticky and ignores new instructions until reset.
    issue(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    ex_valid = 1'b1; ALU_out = 16'h0022;
    tick();
    ex_valid = 1'b0;
    chk1("err_sticky", err, 1'b1);
    chk1("err_no_wb", wb_valid, 1'b0);
    chk1("err_not_ready", ex_ready, 1'b0);
    do_reset();

    // Both memRead and memWrite set.
    issue(16'h0200, 16'h1111, 1'b1, 1'b1, 1'b0, 0);
    do_reset();

    // Back-to-back ADDs give wb_valid every cycle.
    for (int i = 0; i < 4; i++) issue(16'($urandom), 16'h0000, 1'b0, 1'b0, 1'b0, 0);

    // HALT retires once, then the stage stays halted with ex_valid held high.
    issue(16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
    ex_valid = 1'b1; ALU_out = 16'h0777;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("halted_no_wb", wb_valid, 1'b0);
      chk1("halted_not_ready", ex_ready, 1'b0);
    end
    ex_valid = 1'b0;
    do_reset();

    // Reset in ACCESS cycle 2 drops mem_req and suppresses writeback.
    ex_valid = 1'b1; ALU_out = 16'h0300; memRead = 1'b1;
    tick();
    ex_valid = 1'b0; memRead = 1'b0;
    chk1("rst_acc_c1", mem_req, 1'b1);
    tick();
    chk1("rst_acc_c2", mem_req, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk1("rst_acc_req", mem_req, 1'b0);
    chk1("rst_acc_wb", wb_valid, 1'b0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk1("rst_acc_late_done", wb_valid, 1'b0);
    chk1("rst_acc_ready", ex_ready, 1'b1);

`ifdef MEM_TIMEOUT_EN
    // mem_done on the 15th ACCESS cycle still completes.
    issue(16'h0500, 16'h0000, 1'b1, 1'b0, 1'b0, 14);
    // No mem_done: 15 cycles of request, then ERROR without writeback.
    ex_valid = 1'b1; ALU_out = 16'h0400; memRead = 1'b1;
    tick();
    ex_valid = 1'b0; memRead = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk1("to_mem_req", mem_req, 1'b1);
      tick();
    end
    chk1("to_req_drop", mem_req, 1'b0);
    chk1("to_err", err, 1'b1);
    chk1("to_no_wb", wb_valid, 1'b0);
    do_reset();
`endif

    // Randomized traffic over a small address window so loads hit earlier stores.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      a = 16'(2 * $urandom_range(0, 7));
      w = 16'($urandom);
      if (k <= 3) begin
        issue(16'($urandom), w, 1'b0, 1'b0, 1'b0, 0);
      end else if (k <= 5) begin
        issue(a, w, 1'b1, 1'b0, 1'b0, $urandom_range(0, 4));
      end else if (k <= 7) begin
        issue(a, w, 1'b0, 1'b1, 1'b0, $urandom_range(0, 4));
      end else if (k == 8) begin
        if ($urandom_range(0, 1) == 1) issue(a, w, 1'b1, 1'b1, 1'b0, 0);
        else issue(a | 16'h0001, w, 1'($urandom), 1'b1, 1'b0, 0);
        do_reset();
      end else begin
        issue(a, w, 1'b1, 1'b0, 1'b0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of execute.
- Consumes the execute stage's ALU result, which serves as both address and non-memory result, together with the store data.
- Performs loads and stores over a variable-latency request/done memory port and registers the result for writeback.
- Stalls execute through a ready signal while an access is outstanding.

Parameters:
- TIMEOUT, 15: maximum number of ACCESS cycles waited for mem_done. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets).
- ex_valid  in  1  execute presents a valid instruction this cycle.
- ALU_out  in  16  execute result; memory address for load/store.
- read2Data  in  16  store data.
- memRead  in  1  instruction is a load.
- memWrite  in  1  instruction is a store.
- halt  in  1  instruction is HALT.
- ex_ready  out  1  stage accepts an instruction this cycle.
- mem_req  out  1  memory request active.
- mem_wr  out  1  request is a write (valid while mem_req).
- mem_addr  out  16  request address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid when mem_done=1.
- mem_done  in  1  memory completes the current request this cycle.
- wb_valid  out  1  one-cycle pulse: wb_data/wb_halt valid for writeback.
- wb_data  out  16  load data, or captured ALU_out for non-loads.
- wb_halt  out  1  retiring instruction is HALT.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE. All outputs 0 except ex_ready, which returns to 1 in IDLE. Captured registers cleared. Reset during ACCESS drops mem_req the following cycle and suppresses wb_valid.
- States: IDLE, ACCESS, HALTED, ERROR.
- ex_ready = (state==IDLE). Capture occurs only on ex_valid && ex_ready. ex_valid while ex_ready=0 is ignored; upstream holds its inputs.
- IDLE, non-memory capture (memRead=memWrite=0):
  - Next cycle: wb_valid=1, wb_data=ALU_out, wb_halt=halt. Latency 1.
  - If halt=1, go to HALTED; otherwise stay in IDLE. Back-to-back captures give wb_valid every cycle.
- IDLE, memory capture: address, data, and type are registered.
  - memRead && memWrite both high: go to ERROR, no request issued.
  - ALU_out[0]=1 (misaligned 16-bit word): go to ERROR, no request issued.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req=1, mem_wr=captured memWrite, mem_addr/mem_wdata held constant.
  - mem_done sampled at an edge leaves ACCESS for IDLE. The next cycle has wb_valid=1, wb_data=mem_rdata for loads or captured ALU_out for stores, and mem_req=0.
  - Minimum latency from capture to wb_valid: 2 cycles (mem_done in the first ACCESS cycle).
  - mem_done outside ACCESS is ignored.
- HALTED: terminal until reset; ex_ready=0, mem_req=0, wb_valid=0.
- ERROR: terminal until reset; err=1 (set in the cycle after detection), ex_ready=0, mem_req=0, wb_valid=0.
- wb_valid is never high for more than one cycle per instruction. wb_data and wb_halt hold their last value when wb_valid=0.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 4-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle without mem_done.
  - Reaching TIMEOUT without mem_done goes to ERROR: mem_req drops next cycle, err=1, no wb_valid.
  - mem_done on the same edge the count reaches TIMEOUT wins: the access completes normally.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Reset, then ADD result: ALU_out=0x1234, no memory flags, ex_valid 1 cycle -> next cycle wb_valid=1, wb_data=0x1234, mem_req never 1, ex_ready stays 1.
- Load at 0x0040, mem_done after 3 ACCESS cycles with mem_rdata=0xBEEF -> mem_req=1 with mem_addr=0x0040 and mem_wr=0 for 3 cycles, ex_ready=0 throughout, then wb_valid=1 with wb_data=0xBEEF.
- Store 0x5A5A to 0x0100, mem_done in the first ACCESS cycle -> one cycle of mem_req=1, mem_wr=1, mem_wdata=0x5A5A; wb_valid 2 cycles after capture with wb_data=0x0100.
- Load at 0x0041 -> no mem_req, err=1 next cycle, ex_ready=0 until rst=0; after reset err=0 and ex_ready=1.
- HALT captured, then ex_valid held high with ADDs -> wb_valid=1 with wb_halt=1 once, then ex_ready=0 and no further wb_valid.
- MEM_TIMEOUT_EN, TIMEOUT=15: load with mem_done never asserted -> mem_req high 15 cycles, then err=1, mem_req=0, no wb_valid. Separate run: rst=0 asserted in ACCESS cycle 2 -> mem_req=0 after that edge, no wb_valid.
